// File: rtl/button_event_decoder.sv
// Button gesture decoder: turns a debounced, synchronous button level into
// short / double / long / auto-repeat pulses plus a running event count.
module button_event_decoder #(
    parameter int unsigned LONG_PRESS_NUM_CLKS       = 8,
    parameter int unsigned DOUBLE_CLICK_GAP_NUM_CLKS = 6,
    parameter int unsigned REPEAT_NUM_CLKS           = 4,
    parameter int unsigned CLOCK_FREQUENCY           = 50000000
) (
    input  logic       IN_CLOCK,
    input  logic       IN_RESET,
    input  logic       IN_DEBOUNCE_SIGNAL,
    output logic       OUT_SHORT_PRESS,
    output logic       OUT_DOUBLE_PRESS,
    output logic       OUT_LONG_PRESS,
    output logic       OUT_REPEAT,
    output logic [7:0] OUT_EVENT_COUNT,
    output logic [2:0] OUT_STATE
);

    localparam int unsigned MAX_A  = (LONG_PRESS_NUM_CLKS > DOUBLE_CLICK_GAP_NUM_CLKS) ?
                                     LONG_PRESS_NUM_CLKS : DOUBLE_CLICK_GAP_NUM_CLKS;
    localparam int unsigned MAX_P  = (MAX_A > REPEAT_NUM_CLKS) ? MAX_A : REPEAT_NUM_CLKS;
    localparam int unsigned CW     = $clog2(MAX_P + 1) + 1;

    // Each threshold is hit when the in-state counter reads N-1 at the edge.
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_NUM_CLKS - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(DOUBLE_CLICK_GAP_NUM_CLKS - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_NUM_CLKS - 1);

    // CLOCK_FREQUENCY is informational; it only takes part in this sanity guard.
    if (LONG_PRESS_NUM_CLKS < 2 || DOUBLE_CLICK_GAP_NUM_CLKS < 2 ||
        REPEAT_NUM_CLKS < 2 || CLOCK_FREQUENCY == 0) begin : g_illegal_params
    end

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT_GAP  = 3'd2,
        PRESS2    = 3'd3,
        LONG_HELD = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          prev_q;
    logic          short_q, short_d;
    logic          double_q, double_d;
    logic          long_q, long_d;
    logic          rep_q, rep_d;
    logic [7:0]    evcnt_q, evcnt_d;
    logic          rise, fall, restart;

    always_comb begin
        rise     = IN_DEBOUNCE_SIGNAL & ~prev_q;
        fall     = ~IN_DEBOUNCE_SIGNAL & prev_q;
        state_d  = state_q;
        restart  = 1'b0;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        rep_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) state_d = PRESS1;
            end
            PRESS1: begin
                if (fall) begin
                    state_d = WAIT_GAP;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = LONG_HELD;
                end
            end
            WAIT_GAP: begin
                if (rise) begin
                    state_d = PRESS2;
                end else if (cnt_q == GAP_LAST) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                end
            end
            PRESS2: begin
                if (fall) begin
                    double_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    state_d = IDLE;
                end else if (cnt_q == REP_LAST) begin
                    rep_d   = 1'b1;
                    restart = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Repeat pulses re-enter LONG_HELD, so they restart the counter like any entry.
        if (state_d != state_q || restart) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end

        evcnt_d = evcnt_q + {7'd0, (short_d | double_d | long_d | rep_d)};
    end

    always_ff @(posedge IN_CLOCK) begin
        prev_q <= IN_DEBOUNCE_SIGNAL;
        if (IN_RESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            rep_q    <= 1'b0;
            evcnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            double_q <= double_d;
            long_q   <= long_d;
            rep_q    <= rep_d;
            evcnt_q  <= evcnt_d;
        end
    end

    assign OUT_SHORT_PRESS  = short_q;
    assign OUT_DOUBLE_PRESS = double_q;
    assign OUT_LONG_PRESS   = long_q;
    assign OUT_REPEAT       = rep_q;
    assign OUT_EVENT_COUNT  = evcnt_q;
    assign OUT_STATE        = state_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder: gestures, boundary edges, reset aborts, count wrap.
module tb_button_event_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b0;
    logic       o_short, o_double, o_long, o_rep;
    logic [7:0] o_cnt;
    logic [2:0] o_state;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] SHRT = 4'b1000;
    localparam logic [3:0] DBL  = 4'b0100;
    localparam logic [3:0] LNG  = 4'b0010;
    localparam logic [3:0] REP  = 4'b0001;

    button_event_decoder #(
        .LONG_PRESS_NUM_CLKS(8),
        .DOUBLE_CLICK_GAP_NUM_CLKS(6),
        .REPEAT_NUM_CLKS(4),
        .CLOCK_FREQUENCY(50000000)
    ) dut (
        .IN_CLOCK(clk),
        .IN_RESET(rst),
        .IN_DEBOUNCE_SIGNAL(din),
        .OUT_SHORT_PRESS(o_short),
        .OUT_DOUBLE_PRESS(o_double),
        .OUT_LONG_PRESS(o_long),
        .OUT_REPEAT(o_rep),
        .OUT_EVENT_COUNT(o_cnt),
        .OUT_STATE(o_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Drive a level, take one edge, then check events {short,double,long,repeat}, count, state.
    task automatic tick_chk(input logic lvl, input logic [3:0] ev, input logic [7:0] cnt,
                            input logic [2:0] st, input string tag);
        din = lvl;
        @(posedge clk);
        #1;
        chk({tag, ".events"}, {4'd0, o_short, o_double, o_long, o_rep}, {4'd0, ev});
        chk({tag, ".count"}, o_cnt, cnt);
        chk({tag, ".state"}, {5'd0, o_state}, {5'd0, st});
    endtask

    task automatic hold(input logic lvl, input int n, input logic [7:0] cnt,
                        input logic [2:0] st, input string tag);
        for (int i = 0; i < n; i++) tick_chk(lvl, NONE, cnt, st, tag);
    endtask

    task automatic tick(input logic lvl);
        din = lvl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick_chk(1'b0, NONE, 8'd0, 3'd0, "reset0");
        tick_chk(1'b0, NONE, 8'd0, 3'd0, "reset1");
        rst = 1'b0;
        hold(1'b0, 2, 8'd0, 3'd0, "idle");

        // Single short press: 3 high, then low; short pulse 6 edges after the fall
        tick_chk(1'b1, NONE, 8'd0, 3'd1, "sp.rise");
        hold(1'b1, 2, 8'd0, 3'd1, "sp.high");
        tick_chk(1'b0, NONE, 8'd0, 3'd2, "sp.fall");
        hold(1'b0, 5, 8'd0, 3'd2, "sp.gap");
        tick_chk(1'b0, SHRT, 8'd1, 3'd0, "sp.pulse");
        hold(1'b0, 4, 8'd1, 3'd0, "sp.after");

        // Double press: 3 high, 2 low, 3 high, fall
        tick_chk(1'b1, NONE, 8'd1, 3'd1, "dp.rise1");
        hold(1'b1, 2, 8'd1, 3'd1, "dp.high1");
        tick_chk(1'b0, NONE, 8'd1, 3'd2, "dp.fall1");
        hold(1'b0, 1, 8'd1, 3'd2, "dp.gap");
        tick_chk(1'b1, NONE, 8'd1, 3'd3, "dp.rise2");
        hold(1'b1, 2, 8'd1, 3'd3, "dp.high2");
        tick_chk(1'b0, DBL, 8'd2, 3'd0, "dp.pulse");
        hold(1'b0, 7, 8'd2, 3'd0, "dp.noshort");

        // Long press held 20 clocks: long at E0+8, repeats at E0+12/16, fall at E0+20 suppresses repeat
        tick_chk(1'b1, NONE, 8'd2, 3'd1, "lp.rise");
        hold(1'b1, 7, 8'd2, 3'd1, "lp.pre");
        tick_chk(1'b1, LNG, 8'd3, 3'd4, "lp.long");
        hold(1'b1, 3, 8'd3, 3'd4, "lp.h1");
        tick_chk(1'b1, REP, 8'd4, 3'd4, "lp.rep1");
        hold(1'b1, 3, 8'd4, 3'd4, "lp.h2");
        tick_chk(1'b1, REP, 8'd5, 3'd4, "lp.rep2");
        hold(1'b1, 3, 8'd5, 3'd4, "lp.h3");
        tick_chk(1'b0, NONE, 8'd5, 3'd0, "lp.fall");
        hold(1'b0, 3, 8'd5, 3'd0, "lp.idle");

        // Rise exactly on the last gap edge wins over expiry
        tick_chk(1'b1, NONE, 8'd5, 3'd1, "gb.rise1");
        hold(1'b1, 2, 8'd5, 3'd1, "gb.high1");
        tick_chk(1'b0, NONE, 8'd5, 3'd2, "gb.fall1");
        hold(1'b0, 5, 8'd5, 3'd2, "gb.gap");
        tick_chk(1'b1, NONE, 8'd5, 3'd3, "gb.rise_last");
        tick_chk(1'b0, DBL, 8'd6, 3'd0, "gb.double");

        // Fall exactly on the long threshold edge wins: no long pulse, short later
        tick_chk(1'b1, NONE, 8'd6, 3'd1, "lb.rise");
        hold(1'b1, 7, 8'd6, 3'd1, "lb.high");
        tick_chk(1'b0, NONE, 8'd6, 3'd2, "lb.fall_thr");
        hold(1'b0, 5, 8'd6, 3'd2, "lb.gap");
        tick_chk(1'b0, SHRT, 8'd7, 3'd0, "lb.short");

        // Reset in WAIT_GAP with input high through release
        tick_chk(1'b1, NONE, 8'd7, 3'd1, "rw.rise");
        tick_chk(1'b0, NONE, 8'd7, 3'd2, "rw.fall");
        hold(1'b0, 2, 8'd7, 3'd2, "rw.gap");
        rst = 1'b1;
        tick_chk(1'b1, NONE, 8'd0, 3'd0, "rw.rst0");
        tick_chk(1'b1, NONE, 8'd0, 3'd0, "rw.rst1");
        rst = 1'b0;
        hold(1'b1, 10, 8'd0, 3'd0, "rw.held");

        // Reset in LONG_HELD with input high through release
        tick_chk(1'b0, NONE, 8'd0, 3'd0, "rl.release");
        tick_chk(1'b1, NONE, 8'd0, 3'd1, "rl.rise");
        hold(1'b1, 7, 8'd0, 3'd1, "rl.pre");
        tick_chk(1'b1, LNG, 8'd1, 3'd4, "rl.long");
        hold(1'b1, 2, 8'd1, 3'd4, "rl.h");
        rst = 1'b1;
        tick_chk(1'b1, NONE, 8'd0, 3'd0, "rl.rst");
        rst = 1'b0;
        hold(1'b1, 10, 8'd0, 3'd0, "rl.held");
        hold(1'b0, 8, 8'd0, 3'd0, "rl.low");
        tick_chk(1'b1, NONE, 8'd0, 3'd1, "rl.newpress");
        tick_chk(1'b0, NONE, 8'd0, 3'd2, "rl.newfall");
        hold(1'b0, 5, 8'd0, 3'd2, "rl.gap");
        tick_chk(1'b0, SHRT, 8'd1, 3'd0, "rl.short");

        // 257 short presses from a clean reset: count wraps to 1
        rst = 1'b1;
        tick_chk(1'b0, NONE, 8'd0, 3'd0, "wr.rst");
        rst = 1'b0;
        for (int p = 1; p <= 257; p++) begin
            tick(1'b1);
            for (int k = 0; k < 6; k++) tick(1'b0);
            tick_chk(1'b0, SHRT, 8'(p), 3'd0, "wr.press");
        end
        tick_chk(1'b0, NONE, 8'd1, 3'd0, "wr.final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
